cnn_host_seq: RTL and testbench

- Hardware initiator for the CNN accelerator's memory-mapped register interface; replaces CPU-driven load/start/poll/read sequencing.
- Accepts a byte stream of 25 image pixels followed by 9 kernel weights and writes them to the accelerator with indexed write words.
- Issues the start write, waits for the accelerator's done, reads the 9 results and emits them on a valid/ready result stream.
- Sits between a data source (DMA/UART FIFO) and cnn_accel.

---
 rtl/cnn_host_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_cnn_host_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_host_seq.sv
// Hardware sequencer for cnn_accel: streams image/kernel bytes into the register
// interface, kicks off a run, waits for done and drains results on a valid/ready stream.
module cnn_host_seq #(
  parameter int          IMG_N      = 25,
  parameter int          KER_N      = 9,
  parameter int          RES_N      = 9,
  parameter logic [31:0] IMG_ADDR   = 32'h004,
  parameter logic [31:0] KER_ADDR   = 32'h008,
  parameter logic [31:0] START_ADDR = 32'h00C,
  parameter logic [31:0] RES_BASE   = 32'h080,
  parameter int          TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done_o,
  output logic        err,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [7:0]  src_data,
  output logic        cnn_en,
  output logic        w_en,
  output logic [31:0] w_addr,
  output logic [31:0] wdata,
  output logic        r_en,
  output logic [31:0] r_addr,
  input  logic [31:0] rdata,
  input  logic        acc_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [3:0]  res_idx
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_IMG, S_LOAD_KER, S_START, S_WAIT_DONE,
    S_READ_REQ, S_READ_CAP, S_OUT, S_FINISH
  } state_t;

  state_t        state, state_n;
  logic [15:0]   idx, idx_n;
  logic [3:0]    res_cnt, res_cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;

  logic        busy_n, done_n, err_n, src_ready_n, cnn_en_n, w_en_n, r_en_n, res_valid_n;
  logic [31:0] w_addr_n, wdata_n, r_addr_n;
  logic [15:0] res_data_n;
  logic [3:0]  res_idx_n;
  logic        accept;

  logic unused_rdata;
  assign unused_rdata = ^rdata[31:16];

  assign accept = src_valid && src_ready;

  // Every output is computed one cycle ahead here and registered below.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    res_cnt_n   = res_cnt;
    tcnt_n      = tcnt;
    busy_n      = busy;
    cnn_en_n    = cnn_en;
    done_n      = 1'b0;
    err_n       = err;
    src_ready_n = src_ready;
    w_en_n      = 1'b0;
    w_addr_n    = w_addr;
    wdata_n     = wdata;
    r_en_n      = r_en;
    r_addr_n    = r_addr;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    res_idx_n   = res_idx;

    if (abort) begin
      state_n     = S_IDLE;
      busy_n      = 1'b0;
      cnn_en_n    = 1'b0;
      err_n       = 1'b0;
      src_ready_n = 1'b0;
      r_en_n      = 1'b0;
      res_valid_n = 1'b0;
      idx_n       = '0;
      res_cnt_n   = '0;
      tcnt_n      = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_n     = S_LOAD_IMG;
            busy_n      = 1'b1;
            cnn_en_n    = 1'b1;
            src_ready_n = 1'b1;
            err_n       = 1'b0;
            idx_n       = '0;
          end
        end
        S_LOAD_IMG: begin
          if (accept) begin
            w_en_n   = 1'b1;
            w_addr_n = IMG_ADDR;
            wdata_n  = {idx, 8'h00, src_data};
            if (idx == 16'(IMG_N - 1)) begin
              idx_n       = '0;
              src_ready_n = 1'b0;
              state_n     = S_LOAD_KER;
            end else begin
              idx_n = idx + 16'd1;
            end
          end
        end
        S_LOAD_KER: begin
          // src_ready is low for the first cycle here, so no byte slips in on the switch.
          src_ready_n = 1'b1;
          if (accept) begin
            w_en_n   = 1'b1;
            w_addr_n = KER_ADDR;
            wdata_n  = {idx, 8'h00, src_data};
            if (idx == 16'(KER_N - 1)) begin
              idx_n       = '0;
              src_ready_n = 1'b0;
              state_n     = S_START;
            end else begin
              idx_n = idx + 16'd1;
            end
          end
        end
        S_START: begin
          w_en_n   = 1'b1;
          w_addr_n = START_ADDR;
          wdata_n  = 32'h1;
          tcnt_n   = '0;
          state_n  = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // tcnt==0 is the cycle the start write lands, so a done left over from the last run is ignored.
          if (tcnt != '0 && acc_done) begin
            state_n   = S_READ_REQ;
            res_cnt_n = '0;
            r_en_n    = 1'b1;
            r_addr_n  = RES_BASE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state_n = S_FINISH;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
        S_READ_REQ: state_n = S_READ_CAP;
        S_READ_CAP: begin
          r_en_n      = 1'b0;
          res_valid_n = 1'b1;
          res_idx_n   = res_cnt;
          res_data_n  = rdata[15:0];
          state_n     = S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid_n = 1'b0;
            res_cnt_n   = res_cnt + 4'd1;
            if (res_cnt_n == 4'(RES_N)) begin
              state_n = S_FINISH;
              done_n  = 1'b1;
              err_n   = 1'b0;
            end else begin
              state_n  = S_READ_REQ;
              r_en_n   = 1'b1;
              r_addr_n = RES_BASE + (32'(res_cnt_n) << 2);
            end
          end
        end
        S_FINISH: begin
          busy_n   = 1'b0;
          cnn_en_n = 1'b0;
          err_n    = 1'b0;
          state_n  = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      res_cnt   <= '0;
      tcnt      <= '0;
      busy      <= 1'b0;
      cnn_en    <= 1'b0;
      done_o    <= 1'b0;
      err       <= 1'b0;
      src_ready <= 1'b0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      wdata     <= '0;
      r_en      <= 1'b0;
      r_addr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      res_cnt   <= res_cnt_n;
      tcnt      <= tcnt_n;
      busy      <= busy_n;
      cnn_en    <= cnn_en_n;
      done_o    <= done_n;
      err       <= err_n;
      src_ready <= src_ready_n;
      w_en      <= w_en_n;
      w_addr    <= w_addr_n;
      wdata     <= wdata_n;
      r_en      <= r_en_n;
      r_addr    <= r_addr_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
      res_idx   <= res_idx_n;
    end
  end

endmodule

// File: tb/tb_cnn_host_seq.sv
// Scoreboard bench for cnn_host_seq: expected writes/results/done pulses are queued
// when a run is issued and popped by an independent monitor on the falling edge.
module tb_cnn_host_seq;

  localparam logic [31:0] IMG_A   = 32'h004;
  localparam logic [31:0] KER_A   = 32'h008;
  localparam logic [31:0] START_A = 32'h00C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = 8'h00;
  logic        res_ready = 1'b1;
  logic [31:0] rdata = 32'h0;
  logic        acc_done;
  logic        busy, done_o, err, src_ready, cnn_en, w_en, r_en, res_valid;
  logic [31:0] w_addr, wdata, r_addr;
  logic [15:0] res_data;
  logic [3:0]  res_idx;

  cnn_host_seq #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done_o(done_o), .err(err),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .cnn_en(cnn_en),
    .w_en(w_en), .w_addr(w_addr), .wdata(wdata), .r_en(r_en), .r_addr(r_addr), .rdata(rdata),
    .acc_done(acc_done), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;

  logic [63:0] wr_q[$];
  logic [19:0] res_q[$];
  logic        done_q[$];

  function automatic void checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void flagEvent(string name);
    n_checks++;
    $display("[TB] FAIL %s: DUT produced an event with nothing expected", name);
  endfunction

  function automatic logic [15:0] res_val(int j);
    case (j)
      0: res_val = 16'd411;
      1: res_val = 16'd456;
      2: res_val = 16'd501;
      3: res_val = 16'd636;
      4: res_val = 16'd681;
      5: res_val = 16'd726;
      6: res_val = 16'd861;
      7: res_val = 16'd906;
      8: res_val = 16'd951;
      default: res_val = 16'hFFFF;
    endcase
  endfunction

  // Accelerator model: done drops on the start write, rises a few cycles later and stays up.
  logic stale_hold = 1'b0, never_done = 1'b0;
  logic m_done, m_run;
  int   m_cnt;
  assign acc_done = m_done | stale_hold;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_done <= 1'b0;
      m_run  <= 1'b0;
      m_cnt  <= 0;
    end else if (w_en && w_addr == START_A) begin
      m_done <= 1'b0;
      m_run  <= 1'b1;
      m_cnt  <= 5;
    end else if (m_run) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else begin
        m_run  <= 1'b0;
        m_done <= !never_done;
      end
    end
  end

  always @(posedge clk) begin
    if (r_en) rdata <= {16'hBEEF, res_val(int'((r_addr - 32'h080) >> 2))};
  end

  // Result consumer: stalls for 5 cycles when result bp_idx is presented.
  int bp_idx = -1;
  int bp_held = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (res_valid && int'(res_idx) == bp_idx && bp_held < 5) begin
        res_ready = 1'b0;
        bp_held++;
      end else begin
        res_ready = 1'b1;
        if (!res_valid) bp_held = 0;
      end
    end
  end

  int rd_total = 0, done_total = 0, start_cyc = 0, done_cyc = 0, first_rd_cyc = 0;
  bit rd_seen = 1'b0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_acc = 1'b0;
  logic [15:0] prev_data = '0;
  logic [3:0]  prev_idx = '0;

  initial begin
    logic [63:0] we;
    logic [19:0] re;
    logic        de;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (w_en && r_en) checkOutput("rw_exclusive", {w_en, r_en}, 2'b10);
        if (w_en) begin
          if (w_addr == IMG_A || w_addr == KER_A) checkOutput("wr_after_accept", prev_acc, 1'b1);
          if (w_addr == START_A) begin
            start_cyc = cyc;
            rd_seen   = 1'b0;
          end
          if (wr_q.size() == 0) flagEvent("unexpected_write");
          else begin
            we = wr_q.pop_front();
            checkOutput("wr_addr", w_addr, we[63:32]);
            checkOutput("wr_data", wdata, we[31:0]);
          end
        end
        if (r_en) begin
          rd_total++;
          if (!rd_seen) begin
            rd_seen      = 1'b1;
            first_rd_cyc = cyc;
          end
        end
        if (prev_valid && !prev_ready && res_valid) begin
          checkOutput("stall_data_stable", res_data, prev_data);
          checkOutput("stall_idx_stable", res_idx, prev_idx);
        end
        if (res_valid && res_ready) begin
          if (res_q.size() == 0) flagEvent("unexpected_result");
          else begin
            re = res_q.pop_front();
            checkOutput("res_idx", res_idx, re[19:16]);
            checkOutput("res_data", res_data, re[15:0]);
          end
        end
        if (done_o) begin
          done_total++;
          done_cyc = cyc;
          if (done_q.size() == 0) flagEvent("unexpected_done");
          else begin
            de = done_q.pop_front();
            checkOutput("done_err", err, de);
          end
        end
      end
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_data  = res_data;
      prev_idx   = res_idx;
      prev_acc   = src_valid && src_ready;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    src_valid = 1'b1;
    src_data  = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (src_ready) break;
    end
    if (n == 200) flagEvent("src_ready_timeout");
    @(posedge clk); #1 src_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_loads(input logic [7:0] ib, input logic [7:0] kb, input int nimg,
                            input int nker, input bit with_start);
    for (int k = 0; k < nimg; k++) wr_q.push_back({IMG_A, 16'(k), 8'h00, 8'(ib + k)});
    for (int k = 0; k < nker; k++) wr_q.push_back({KER_A, 16'(k), 8'h00, 8'(kb + k)});
    if (with_start) wr_q.push_back({START_A, 32'h1});
  endtask

  task automatic wait_done(input int base);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done_total > base) return;
    end
    flagEvent("done_timeout");
  endtask

  task automatic applyStimulus(input logic [7:0] ib, input logic [7:0] kb, input bit gaps,
                               input bit to_mode);
    int rd_base = rd_total;
    int d_base  = done_total;
    push_loads(ib, kb, 25, 9, 1'b1);
    if (!to_mode) for (int j = 0; j < 9; j++) res_q.push_back({4'(j), res_val(j)});
    done_q.push_back(to_mode);
    pulse_start();
    for (int k = 0; k < 25; k++) send_byte(8'(ib + k), gaps);
    for (int k = 0; k < 9; k++) send_byte(8'(kb + k), gaps);
    wait_done(d_base);
    @(negedge clk);
    checkOutput("wr_q_drained", wr_q.size(), 0);
    checkOutput("res_q_drained", res_q.size(), 0);
    checkOutput("read_cycles", rd_total - rd_base, to_mode ? 0 : 18);
    if (to_mode) checkOutput("timeout_latency", done_cyc - start_cyc, 16);
    checkOutput("idle_after_finish", {busy, cnn_en, err, done_o}, 4'b0000);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_outputs", {busy, done_o, err, src_ready, cnn_en, w_en, w_addr, wdata,
                                  r_en, r_addr, res_valid, res_data, res_idx}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] nominal run");
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);

    $display("[TB] source gaps");
    applyStimulus(8'h40, 8'h80, 1'b1, 1'b0);

    $display("[TB] backpressure at result 3");
    bp_idx = 3;
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);
    bp_idx = -1;

    $display("[TB] timeout");
    never_done = 1'b1;
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b1);
    never_done = 1'b0;

    $display("[TB] stale done");
    stale_hold = 1'b1;
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);
    checkOutput("stale_done_masked", first_rd_cyc - start_cyc, 2);
    stale_hold = 1'b0;

    $display("[TB] abort at kernel byte 4");
    push_loads(8'd1, 8'd1, 25, 3, 1'b0);
    pulse_start();
    for (int k = 0; k < 25; k++) send_byte(8'(1 + k), 1'b0);
    for (int k = 0; k < 3; k++) send_byte(8'(1 + k), 1'b0);
    src_valid = 1'b1;
    src_data  = 8'd4;
    abort     = 1'b1;
    @(posedge clk); #1;
    abort     = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", {busy, cnn_en, src_ready, w_en, r_en, done_o, err}, 7'b0);
    checkOutput("abort_writes", wr_q.size(), 0);
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);

    $display("[TB] reset during result output");
    bp_idx = 0;
    push_loads(8'd1, 8'd1, 25, 9, 1'b1);
    for (int j = 0; j < 9; j++) res_q.push_back({4'(j), res_val(j)});
    done_q.push_back(1'b0);
    pulse_start();
    for (int k = 0; k < 25; k++) send_byte(8'(1 + k), 1'b0);
    for (int k = 0; k < 9; k++) send_byte(8'(1 + k), 1'b0);
    begin
      int n;
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (res_valid) break;
      end
      if (n == 200) flagEvent("res_valid_timeout");
    end
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_mid_run", {busy, done_o, err, src_ready, cnn_en, w_en, w_addr, wdata,
                                  r_en, r_addr, res_valid, res_data, res_idx}, '0);
    wr_q.delete();
    res_q.delete();
    done_q.delete();
    bp_idx = -1;
    @(posedge clk); #1 rst = 1'b1;
    applyStimulus(8'd1, 8'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
